// File: rtl/print_pkg.sv
// Shared service codes, FSM state type and ASCII helpers for the print formatter.
package print_pkg;

  localparam logic [15:0] CMD_HEX = 16'h0001;
  localparam logic [15:0] CMD_DEC = 16'h0002;
  localparam logic [15:0] CMD_CHR = 16'h0003;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_LC  = 8'h61;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StConv,
    StEmit
  } pf_state_t;

  // Lowercase hex digit; also valid for BCD digits 0-9.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'h0, nib};
    end
    return ASCII_A_LC + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to five BCD digits in 16 cycles.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [4:0]  cnt_q;
  logic [19:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= 5'd16;
    end else if (cnt_q != 5'd0) begin
      bcd_q <= {adj[18:0], bin_q[15]};
      bin_q <= {bin_q[14:0], 1'b0};
      cnt_q <= cnt_q - 5'd1;
    end
  end

  // High during the cycle whose edge performs the final step; bcd is final next cycle.
  assign done = (cnt_q == 5'd1);
  assign bcd  = bcd_q;

endmodule

// File: rtl/print_formatter.sv
// Console stage: on a HEX/DEC/CHR service code, reads the argument word from memory
// and streams its ASCII text over a valid/ready byte interface.
module print_formatter
  import print_pkg::*;
#(
  parameter logic [15:0] MEM_ADDR = 16'h0000,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  output logic [15:0] mem_sel,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic        cmd_drop
);

  pf_state_t   state_q, state_d;
  logic [15:0] cmd_q;
  logic [15:0] code_q, code_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  last_idx;
  logic        req, last_wait, bcd_start, bcd_done;
  logic [19:0] bcd;
  logic [31:0] bcd_ext;
  logic [3:0]  hex_nib, dec_dig;
  logic [2:0]  dec_pos;
  logic        dec_blank;

  // Edge-detected so a code held on data_out triggers only once.
  assign req = (cmd != cmd_q) && ((cmd == CMD_HEX) || (cmd == CMD_DEC) || (cmd == CMD_CHR));
  assign busy      = (state_q != StIdle);
  assign cmd_drop  = req && busy;
  assign last_wait = (wait_cnt_q == 2'(MEM_LAT - 1));

  always_comb begin
    if (code_q == CMD_HEX) begin
      last_idx = 3'd3;
    end else if (code_q == CMD_DEC) begin
      last_idx = 3'd4;
    end else begin
      last_idx = 3'd0;
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (mem_data),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    data_d     = data_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    mem_sel    = '0;
    mem_rd     = 1'b0;
    char_valid = 1'b0;
    bcd_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          code_d  = cmd;
          state_d = StFetch;
        end
      end
      StFetch: begin
        mem_sel    = MEM_ADDR;
        mem_rd     = 1'b1;
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        mem_sel = MEM_ADDR;
        if (last_wait) begin
          data_d = mem_data;
          idx_d  = '0;
          if (code_q == CMD_DEC) begin
            bcd_start = 1'b1;
            state_d   = StConv;
          end else begin
            state_d = StEmit;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      StConv: begin
        if (bcd_done) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        char_valid = 1'b1;
        if (char_ready) begin
          if (idx_q == last_idx) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    char_data = '0;
    bcd_ext   = {12'h000, bcd};
    hex_nib   = data_q[{2'd3 - idx_q[1:0], 2'b00} +: 4];
    dec_pos   = 3'd4 - idx_q;
    dec_dig   = bcd_ext[{dec_pos, 2'b00} +: 4];
    // Blank a digit when it and every more significant digit are zero.
    dec_blank = (dec_pos != 3'd0) && ((bcd_ext >> {dec_pos, 2'b00}) == 32'd0);
    if (state_q == StEmit) begin
      if (code_q == CMD_HEX) begin
        char_data = nib2ascii(hex_nib);
      end else if (code_q == CMD_DEC) begin
        char_data = dec_blank ? ASCII_SPACE : nib2ascii(dec_dig);
      end else begin
        char_data = data_q[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      code_q     <= '0;
      data_q     <= '0;
      wait_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd;
      code_q     <= code_d;
      data_q     <= data_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
    end
  end

endmodule
